wb_sdram_arbiter: RTL and testbench
===================================

# wb_sdram_arbiter

Two-master Wishbone B3 arbiter placed in front of the SDRAM controller's Wishbone slave port in the picorv32 SoC. It shares the single SDRAM slave between the CPU data/instruction bus (master 0) and a second bus master such as a DMA engine or debug bridge (master 1). Arbitration is round-robin at bus-cycle granularity: a grant is held for a master's whole `cyc` period, which keeps SDRAM bursts intact. A watchdog aborts any access the slave never acknowledges.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width; select width is `DW/8`.
- `TIMEOUT`, 1023: cycles a strobed access may wait for `ack`/`err` before it is aborted. 0 disables the watchdog. Maximum value is 65535.

Ports:
- `wb_clk_i`  in  1  clock; all logic is on its rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `m0_adr_i`/`m1_adr_i`  in  AW  master address.
- `m0_dat_i`/`m1_dat_i`  in  DW  master write data.
- `m0_sel_i`/`m1_sel_i`  in  DW/8  byte select.
- `m0_we_i`/`m1_we_i`, `m0_cyc_i`/`m1_cyc_i`, `m0_stb_i`/`m1_stb_i`  in  1  Wishbone control.
- `m0_cti_i`/`m1_cti_i`  in  3;  `m0_bte_i`/`m1_bte_i`  in  2  burst tags, passed through.
- `m0_dat_o`/`m1_dat_o`  out  DW  read data; `s_dat_i` broadcast to both masters.
- `m0_ack_o`/`m1_ack_o`, `m0_err_o`/`m1_err_o`  out  1  per-master acknowledge and error.
- `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o`, `s_cyc_o`, `s_stb_o`, `s_cti_o`, `s_bte_o`  out  Wishbone signals to the SDRAM controller.
- `s_dat_i`  in  DW;  `s_ack_i`, `s_err_i`  in  1  slave responses.
- `grant_o`  out  2  one-hot current owner; 00 when idle.
- `timeout_o`  out  1  one-cycle pulse when the watchdog aborts an access.

## Operation
- Registered FSM with states IDLE, GNT0, GNT1, ABORT. The register `last` holds the index of the most recently served master.
- IDLE:
  - Only m0 has `cyc` high: go to GNT0.
  - Only m1 has `cyc` high: go to GNT1.
  - Both have `cyc` high: grant the master that is not `last`.
  - Neither: stay in IDLE.
- GNTx:
  - The `s_*` request outputs equal the `mx_*` inputs combinationally.
  - `mx_ack_o = s_ack_i` and `mx_err_o = s_err_i`. The other master's ack and err are 0.
  - When `mx_cyc_i` falls: set `last = x`. If the other master's `cyc` is high, go directly to its GNT state; otherwise go to IDLE.
- Outside GNTx:
  - `s_cyc_o` and `s_stb_o` are 0.
  - `s_adr_o`, `s_dat_o`, `s_sel_o`, `s_we_o` are 0.
  - `s_cti_o` and `s_bte_o` are 0.
- Watchdog: a 16-bit counter, active only when `TIMEOUT != 0`.
  - It clears when `s_stb_o` is low, when `s_ack_i` or `s_err_i` is high, or when the state is not GNTx.
  - Otherwise it increments.
  - When the counter reaches `TIMEOUT` with no response in that cycle, go to ABORT and set `last = x`.
- ABORT lasts exactly 1 cycle:
  - `mx_err_o = 1` to the aborted master, and `timeout_o = 1`.
  - `s_cyc_o = 0`.
  - Then go to IDLE.
  - If the master keeps `cyc` high, it re-arbitrates with lower priority.
- Slave responses arriving in IDLE or ABORT are ignored and are not forwarded to either master.

## Timing
- Reset values:
  - State is IDLE and `last` is 1, so m0 wins the first tie.
  - Counter is 0.
  - `grant_o` is 00 and `timeout_o` is 0.
  - All `s_*` request outputs are 0.
  - All `mx_ack_o` and `mx_err_o` are 0.
- Arbitration latency: `cyc` rises at edge n in IDLE, the grant registers at edge n+1, and `s_cyc_o` is high during cycle n+1.
- Handover: when m0 drops `cyc` at edge n while m1 is waiting, GNT1 is in effect from edge n+1. There are no idle cycles between owners.
- Data path: `s_ack_i` reaches the owner in the same cycle (0 added latency). Burst tags are unmodified, so a CTI=010 burst stays atomic.
- Timeout: stb held with no ack causes ABORT in cycle TIMEOUT+1 after the first strobed cycle of the grant.
- Reset asserted mid-access: all outputs go to their reset values immediately (asynchronously). There is no pending-ack bookkeeping.
- `mx_dat_o` is always `s_dat_i`. It is valid only when `mx_ack_o` is high.

## Test plan
- Single master: m0 reads 0x100 and the slave acks 3 cycles later with 0xDEADBEEF. Required: `grant_o=01` one cycle after `cyc`, m0 receives 0xDEADBEEF with ack, and m1 never sees ack.
- Tie after reset: m0 and m1 raise `cyc` on the same edge. Required: m0 is served first and m1 is granted on the edge after m0 drops `cyc`, with no idle cycle.
- Fairness: both masters issue 4 back-to-back single writes each. Required: grants alternate 0,1,0,1,... and the slave sees 8 writes with the correct adr/dat/sel.
- Burst integrity: m1 runs an 8-beat CTI=010 burst while m0 requests mid-burst. Required: `grant_o` stays 10 until m1 drops `cyc` after its 8th ack.
- Watchdog: `TIMEOUT=16` and the slave never acks m0. Required: one cycle with m0_err=1 and `timeout_o=1`, `s_cyc_o=0` in that cycle, and a waiting m1 is granted next.
- Reset mid-cycle: assert `wb_rst_i` during GNT1 with stb high. Required: `s_cyc_o=0` and `grant_o=00` before the next clock edge, and the first tie after reset goes to m0.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// Two-master Wishbone B3 arbiter in front of the SDRAM controller slave port.
// Round-robin at bus-cycle granularity: ownership is held for the owner's
// whole cyc period so bursts are never split. A watchdog aborts accesses the
// slave never answers and hands the error back to the stalled master.

// Per-master response steering: forwards the slave response only to the
// current owner, and raises err to a master whose access was aborted.
module wb_sdram_arbiter_port (
  input  logic own,
  input  logic abort,
  input  logic s_ack_i,
  input  logic s_err_i,
  output logic ack_o,
  output logic err_o
);
  assign ack_o = own & s_ack_i;
  assign err_o = (own & s_err_i) | abort;
endmodule

module wb_sdram_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 1023
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  // master 0
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  // master 1
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  // slave
  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  // status
  output logic [1:0]      grant_o,
  output logic            timeout_o
);

  localparam int NM = 2;
  localparam logic [15:0] WD_LIM = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, ABORT} state_t;

  state_t      state, state_nxt;
  logic        last, last_nxt;
  logic [15:0] wd_cnt;
  logic        granted, owner, wd_hit;

  logic [NM-1:0][AW-1:0]   req_adr;
  logic [NM-1:0][DW-1:0]   req_dat;
  logic [NM-1:0][DW/8-1:0] req_sel;
  logic [NM-1:0][2:0]      req_cti;
  logic [NM-1:0][1:0]      req_bte;
  logic [NM-1:0]           req_we, req_cyc, req_stb;
  logic [NM-1:0]           own_v, abort_v, ack_v, err_v;

  assign req_adr = {m1_adr_i, m0_adr_i};
  assign req_dat = {m1_dat_i, m0_dat_i};
  assign req_sel = {m1_sel_i, m0_sel_i};
  assign req_cti = {m1_cti_i, m0_cti_i};
  assign req_bte = {m1_bte_i, m0_bte_i};
  assign req_we  = {m1_we_i,  m0_we_i};
  assign req_cyc = {m1_cyc_i, m0_cyc_i};
  assign req_stb = {m1_stb_i, m0_stb_i};

  assign granted   = (state == GNT0) || (state == GNT1);
  assign owner     = (state == GNT1);
  assign grant_o   = {state == GNT1, state == GNT0};
  assign timeout_o = (state == ABORT);

  // Read data is broadcast; masters only look at it alongside their ack.
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  // Watchdog fires when the strobed access has waited the full limit and the
  // slave still gives no response in this cycle.
  assign wd_hit = (TIMEOUT != 0) && granted && s_stb_o && !s_ack_i && !s_err_i
                  && (wd_cnt == WD_LIM);

  // State and last-served registers.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
    end
  end

  // Arbitration: ties go to the master not served last; ownership released
  // only when the owner drops cyc or the watchdog aborts it.
  always_comb begin
    state_nxt = state;
    last_nxt  = last;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) state_nxt = last ? GNT0 : GNT1;
        else if (m0_cyc_i)        state_nxt = GNT0;
        else if (m1_cyc_i)        state_nxt = GNT1;
      end
      GNT0: begin
        if (!m0_cyc_i) begin
          last_nxt  = 1'b0;
          state_nxt = m1_cyc_i ? GNT1 : IDLE;
        end else if (wd_hit) begin
          last_nxt  = 1'b0;
          state_nxt = ABORT;
        end
      end
      GNT1: begin
        if (!m1_cyc_i) begin
          last_nxt  = 1'b1;
          state_nxt = m0_cyc_i ? GNT0 : IDLE;
        end else if (wd_hit) begin
          last_nxt  = 1'b1;
          state_nxt = ABORT;
        end
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog counter: counts strobed, unanswered cycles of the current owner.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)
      wd_cnt <= '0;
    else if (TIMEOUT == 0 || !granted || !s_stb_o || s_ack_i || s_err_i)
      wd_cnt <= '0;
    else
      wd_cnt <= wd_cnt + 16'd1;
  end

  // Slave request mux: owner's signals pass straight through, zero otherwise.
  always_comb begin
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    s_we_o  = 1'b0;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_cti_o = '0;
    s_bte_o = '0;
    if (granted) begin
      s_adr_o = req_adr[owner];
      s_dat_o = req_dat[owner];
      s_sel_o = req_sel[owner];
      s_we_o  = req_we[owner];
      s_cyc_o = req_cyc[owner];
      s_stb_o = req_stb[owner];
      s_cti_o = req_cti[owner];
      s_bte_o = req_bte[owner];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_port
      assign own_v[gi]   = grant_o[gi];
      assign abort_v[gi] = (state == ABORT) && (last == 1'(gi));
      wb_sdram_arbiter_port u_port (
        .own     (own_v[gi]),
        .abort   (abort_v[gi]),
        .s_ack_i (s_ack_i),
        .s_err_i (s_err_i),
        .ack_o   (ack_v[gi]),
        .err_o   (err_v[gi])
      );
    end
  endgenerate

  assign m0_ack_o = ack_v[0];
  assign m1_ack_o = ack_v[1];
  assign m0_err_o = err_v[0];
  assign m1_err_o = err_v[1];

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter: reset, tie, fairness, single access,
// burst integrity, watchdog abort and asynchronous reset mid-access.
module tb_wb_sdram_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          wb_clk_i = 1'b0;
  logic          wb_rst_i = 1'b0;
  logic [AW-1:0] m0_adr_i, m1_adr_i, s_adr_o;
  logic [DW-1:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o, s_dat_o, s_dat_i;
  logic [3:0]    m0_sel_i, m1_sel_i, s_sel_o;
  logic          m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic [2:0]    m0_cti_i, m1_cti_i, s_cti_o;
  logic [1:0]    m0_bte_i, m1_bte_i, s_bte_o;
  logic          m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic          s_we_o, s_cyc_o, s_stb_o, s_ack_i, s_err_i;
  logic [1:0]    grant_o;
  logic          timeout_o;

  wb_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(16)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_cti_i(m0_cti_i), .m0_bte_i(m0_bte_i),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_cti_i(m1_cti_i), .m1_bte_i(m1_bte_i),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  task automatic m_set(input int m, input logic cyc, input logic [31:0] adr,
                       input logic [31:0] dat, input logic we, input logic [3:0] sel,
                       input logic [2:0] cti);
    if (m == 0) begin
      m0_cyc_i = cyc; m0_stb_i = cyc; m0_adr_i = adr; m0_dat_i = dat;
      m0_we_i = we; m0_sel_i = sel; m0_cti_i = cti;
    end else begin
      m1_cyc_i = cyc; m1_stb_i = cyc; m1_adr_i = adr; m1_dat_i = dat;
      m1_we_i = we; m1_sel_i = sel; m1_cti_i = cti;
    end
  endtask

  function automatic logic [31:0] fa(input int m, input int k);
    return 32'((m + 1) * 4096 + k * 4);
  endfunction
  function automatic logic [31:0] fd(input int m, input int k);
    return 32'hF000_0000 | 32'(m * 256 + k);
  endfunction
  function automatic logic [3:0] fs(input int k);
    return 4'(1 << k);
  endfunction

  initial begin
    int cnt [2];
    int own;
    m_set(0, 0, 0, 0, 0, 0, 0);
    m_set(1, 0, 0, 0, 0, 0, 0);
    m0_bte_i = 0; m1_bte_i = 0;
    s_dat_i = 0; s_ack_i = 0; s_err_i = 0;

    // reset values
    #1 wb_rst_i = 1'b1;
    #2;
    chk("rst_grant", grant_o, 2'b00);
    chk("rst_scyc", s_cyc_o, 0);
    chk("rst_sstb", s_stb_o, 0);
    chk("rst_sadr", s_adr_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_acks", {m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}, 0);
    #20 wb_rst_i = 1'b0;
    tick;

    // tie after reset: m0 first, then m1 with no idle cycle
    m_set(0, 1, 32'hA0, 0, 0, 4'hF, 0);
    m_set(1, 1, 32'hB0, 0, 0, 4'hF, 0);
    #1 chk("tie_pre_grant", grant_o, 2'b00);
    tick;
    chk("tie_grant0", grant_o, 2'b01);
    chk("tie_adr0", s_adr_o, 32'hA0);
    s_ack_i = 1; #1;
    chk("tie_ack0", {m0_ack_o, m1_ack_o}, 2'b10);
    tick;
    s_ack_i = 0; m_set(0, 0, 0, 0, 0, 0, 0);
    #1 chk("tie_hold0", grant_o, 2'b01);
    tick;
    chk("tie_grant1", grant_o, 2'b10);
    chk("tie_adr1", s_adr_o, 32'hB0);
    chk("tie_scyc1", s_cyc_o, 1);
    s_ack_i = 1; #1;
    chk("tie_ack1", {m0_ack_o, m1_ack_o}, 2'b01);
    tick;
    s_ack_i = 0; m_set(1, 0, 0, 0, 0, 0, 0);
    tick;
    chk("tie_idle", grant_o, 2'b00);

    // fairness: 4 writes each, grants alternate starting with m0
    cnt[0] = 0; cnt[1] = 0; own = 0;
    m_set(0, 1, fa(0, 0), fd(0, 0), 1, fs(0), 0);
    m_set(1, 1, fa(1, 0), fd(1, 0), 1, fs(0), 0);
    tick;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk("fair_grant", grant_o, (own == 0) ? 2'b01 : 2'b10);
      chk("fair_adr", s_adr_o, fa(own, cnt[own]));
      chk("fair_dat", s_dat_o, fd(own, cnt[own]));
      chk("fair_sel", s_sel_o, fs(cnt[own]));
      chk("fair_we", s_we_o, 1);
      s_ack_i = 1; #1;
      chk("fair_ack", (own == 0) ? {m0_ack_o, m1_ack_o} : {m1_ack_o, m0_ack_o}, 2'b10);
      tick;
      s_ack_i = 0;
      cnt[own]++;
      m_set(own, 0, 0, 0, 0, 0, 0);
      tick;
      if (cnt[own] < 4) m_set(own, 1, fa(own, cnt[own]), fd(own, cnt[own]), 1, fs(cnt[own]), 0);
      own ^= 1;
    end
    #1 chk("fair_idle", grant_o, 2'b00);

    // single master read, ack after 3 cycles
    m_set(0, 1, 32'h100, 0, 0, 4'hF, 0);
    #1 chk("single_pre", grant_o, 2'b00);
    tick;
    chk("single_grant", grant_o, 2'b01);
    chk("single_adr", s_adr_o, 32'h100);
    chk("single_scyc", s_cyc_o, 1);
    chk("single_noack", m0_ack_o, 0);
    tick; tick;
    s_ack_i = 1; s_dat_i = 32'hDEADBEEF; #1;
    chk("single_ack", m0_ack_o, 1);
    chk("single_dat", m0_dat_o, 32'hDEADBEEF);
    chk("single_m1ack", m1_ack_o, 0);
    tick;
    s_ack_i = 0; m_set(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("single_idle", grant_o, 2'b00);
    s_ack_i = 1; #1;
    chk("idle_ack_dropped", {m0_ack_o, m1_ack_o}, 2'b00);
    s_ack_i = 0;

    // burst: m1 8-beat incrementing burst, m0 requests mid-burst
    m_set(1, 1, 32'h200, 0, 0, 4'hF, 3'b010);
    m1_bte_i = 2'b01;
    tick;
    for (int b = 0; b < 8; b++) begin
      #1;
      chk("burst_grant", grant_o, 2'b10);
      chk("burst_adr", s_adr_o, 32'(32'h200 + b * 4));
      chk("burst_cti", s_cti_o, (b == 7) ? 3'b111 : 3'b010);
      if (b == 0) chk("burst_bte", s_bte_o, 2'b01);
      s_ack_i = 1; #1;
      chk("burst_ack", {m0_ack_o, m1_ack_o}, 2'b01);
      tick;
      if (b == 2) m_set(0, 1, 32'h300, 0, 0, 4'hF, 0);
      m1_adr_i = 32'(32'h200 + (b + 1) * 4);
      if (b == 6) m1_cti_i = 3'b111;
    end
    s_ack_i = 0; m_set(1, 0, 0, 0, 0, 0, 0); m1_bte_i = 0;
    #1 chk("burst_hold", grant_o, 2'b10);
    tick;
    chk("burst_handover", grant_o, 2'b01);
    chk("burst_m0adr", s_adr_o, 32'h300);
    s_ack_i = 1;
    tick;
    s_ack_i = 0; m_set(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("burst_idle", grant_o, 2'b00);

    // watchdog: m0 never acked, m1 waiting
    m_set(0, 1, 32'h400, 0, 0, 4'hF, 0);
    tick;
    chk("wd_grant", grant_o, 2'b01);
    m_set(1, 1, 32'h500, 0, 0, 4'hF, 0);
    for (int c = 0; c < 16; c++) tick;
    chk("wd_pre_grant", grant_o, 2'b01);
    chk("wd_pre_timeout", timeout_o, 0);
    chk("wd_pre_err", m0_err_o, 0);
    chk("wd_pre_stb", s_stb_o, 1);
    tick;
    chk("wd_err", {m0_err_o, m1_err_o}, 2'b10);
    chk("wd_timeout", timeout_o, 1);
    chk("wd_scyc", s_cyc_o, 0);
    chk("wd_grant_abort", grant_o, 2'b00);
    m_set(0, 0, 0, 0, 0, 0, 0);
    tick;
    chk("wd_idle", {grant_o, timeout_o}, 3'b000);
    tick;
    chk("wd_m1_grant", grant_o, 2'b10);
    chk("wd_m1_adr", s_adr_o, 32'h500);

    // async reset during GNT1 with stb high
    #2 wb_rst_i = 1'b1;
    #1;
    chk("arst_scyc", s_cyc_o, 0);
    chk("arst_sstb", s_stb_o, 0);
    chk("arst_grant", grant_o, 2'b00);
    chk("arst_sadr", s_adr_o, 0);
    tick;
    m_set(1, 0, 0, 0, 0, 0, 0);
    #2 wb_rst_i = 1'b0;
    tick;
    m_set(0, 1, 32'h600, 0, 0, 4'hF, 0);
    m_set(1, 1, 32'h700, 0, 0, 4'hF, 0);
    tick;
    chk("arst_tie_grant", grant_o, 2'b01);
    chk("arst_tie_adr", s_adr_o, 32'h600);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
